// File: rtl/adc_spi_responder.sv
// adc_spi_responder: ADC front-end model. Runs a timed conversion on cnv,
// returns the held sample over a 1/2/4-lane SPI read, and accepts 24-bit
// register command frames on spi_sdi.
module adc_spi_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int CNV_CYCLES = 14
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cnv,
    output logic                  busy,
    input  logic                  spi_sck,
    input  logic                  spi_csn,
    input  logic                  spi_sdi,
    output logic [3:0]            spi_sdo,
    input  logic [DATA_WIDTH-1:0] sample_data,
    output logic [23:0]           reg_cmd,
    output logic                  reg_cmd_valid,
    output logic [7:0]            status
);

    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam int CW = $clog2(CNV_CYCLES + 1);

    typedef enum logic {
        CONV_IDLE = 1'b0,
        CONV_BUSY = 1'b1
    } conv_state_t;

    // Synchronizer chain: bit 0 cnv, 1 sck, 2 csn, 3 sdi
    logic [3:0] meta_reg;
    logic [3:0] sync_reg;
    logic [2:0] prev_reg;

    logic cnv_s, sck_s, csn_s, sdi_s;
    logic cnv_rise, sck_rise, sck_fall, csn_rise, csn_fall;

    conv_state_t         conv_state_reg, conv_state_next;
    logic [CW-1:0]       cnv_cnt_reg, cnv_cnt_next;
    logic                conv_accept, conv_done;

    logic [DATA_WIDTH-1:0] hold_reg;
    logic                  conv_overrun_reg;
    logic                  data_ready_reg;

    logic                  read_active_reg;
    logic                  conv_in_frame_reg;
    logic [DATA_WIDTH-1:0] out_shift_reg;
    logic [BW-1:0]         bits_left_reg;
    logic [BW-1:0]         grp_bits;
    logic [3:0]            top_nibble;

    logic [23:0] cmd_shift_reg;
    logic [4:0]  cmd_cnt_reg;
    logic [23:0] reg_cmd_reg;
    logic        reg_cmd_valid_reg;
    logic        reg_mode_reg;
    logic [1:0]  lane_mode_reg;

    // Two-flop synchronizers plus one delayed copy for edge detection
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta_reg <= '0;
            sync_reg <= '0;
            prev_reg <= '0;
        end else begin
            meta_reg <= {spi_sdi, spi_csn, spi_sck, cnv};
            sync_reg <= meta_reg;
            prev_reg <= sync_reg[2:0];
        end
    end

    assign cnv_s    = sync_reg[0];
    assign sck_s    = sync_reg[1];
    assign csn_s    = sync_reg[2];
    assign sdi_s    = sync_reg[3];
    assign cnv_rise = cnv_s & ~prev_reg[0];
    assign sck_rise = sck_s & ~prev_reg[1];
    assign sck_fall = ~sck_s & prev_reg[1];
    assign csn_rise = csn_s & ~prev_reg[2];
    assign csn_fall = ~csn_s & prev_reg[2];

    // Conversion state and busy countdown
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            conv_state_reg <= CONV_IDLE;
            cnv_cnt_reg    <= '0;
        end else begin
            conv_state_reg <= conv_state_next;
            cnv_cnt_reg    <= cnv_cnt_next;
        end
    end

    // Conversion next-state: accept a start when idle, finish when the count hits 1
    always_comb begin
        conv_state_next = conv_state_reg;
        cnv_cnt_next    = cnv_cnt_reg;
        conv_accept     = 1'b0;
        conv_done       = 1'b0;
        case (conv_state_reg)
            CONV_IDLE: begin
                if (cnv_rise) begin
                    conv_state_next = CONV_BUSY;
                    cnv_cnt_next    = CW'(CNV_CYCLES);
                    conv_accept     = 1'b1;
                end
            end
            CONV_BUSY: begin
                if (cnv_cnt_reg == CW'(1)) begin
                    conv_state_next = CONV_IDLE;
                    cnv_cnt_next    = '0;
                    conv_done       = 1'b1;
                end else begin
                    cnv_cnt_next = cnv_cnt_reg - CW'(1);
                end
            end
            default: conv_state_next = CONV_IDLE;
        endcase
    end

    assign busy = (conv_state_reg == CONV_BUSY);

    // Sample capture and sticky overrun flag
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hold_reg         <= '0;
            conv_overrun_reg <= 1'b0;
        end else begin
            if (conv_accept)
                hold_reg <= sample_data;
            if (cnv_rise && busy)
                conv_overrun_reg <= 1'b1;
        end
    end

    // data_ready: cleared by a new conversion, set at its end, consumed by a
    // completed readout unless a conversion landed inside that frame
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_ready_reg <= 1'b0;
        end else if (conv_accept) begin
            data_ready_reg <= 1'b0;
        end else if (conv_done) begin
            data_ready_reg <= 1'b1;
        end else if (csn_rise && read_active_reg && !conv_in_frame_reg) begin
            data_ready_reg <= 1'b0;
        end
    end

    // Remember whether a conversion started during the current readout
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            conv_in_frame_reg <= 1'b0;
        end else if (csn_fall) begin
            conv_in_frame_reg <= 1'b0;
        end else if (conv_accept && read_active_reg) begin
            conv_in_frame_reg <= 1'b1;
        end
    end

    // Bits moved per sck; 2'b11 falls back to single lane
    always_comb begin
        grp_bits = BW'(1);
        case (lane_mode_reg)
            2'b01:   grp_bits = BW'(2);
            2'b10:   grp_bits = BW'(4);
            default: grp_bits = BW'(1);
        endcase
    end

    // Readout shifter: load on frame start, advance one group per sck fall
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            read_active_reg <= 1'b0;
            out_shift_reg   <= '0;
            bits_left_reg   <= '0;
        end else if (csn_fall) begin
            if (!reg_mode_reg && data_ready_reg) begin
                read_active_reg <= 1'b1;
                out_shift_reg   <= hold_reg;
                bits_left_reg   <= BW'(DATA_WIDTH);
            end else begin
                read_active_reg <= 1'b0;
            end
        end else if (csn_rise) begin
            read_active_reg <= 1'b0;
        end else if (sck_fall && !csn_s && read_active_reg) begin
            case (lane_mode_reg)
                2'b01:   out_shift_reg <= out_shift_reg << 2;
                2'b10:   out_shift_reg <= out_shift_reg << 4;
                default: out_shift_reg <= out_shift_reg << 1;
            endcase
            if (bits_left_reg > grp_bits)
                bits_left_reg <= bits_left_reg - grp_bits;
            else
                bits_left_reg <= '0;
        end
    end

    assign top_nibble = out_shift_reg[DATA_WIDTH-1 -: 4];

    // Lane mux: MSB group onto the low lanes, unused lanes and idle time at 0
    always_comb begin
        spi_sdo = 4'b0000;
        if (read_active_reg && !csn_s && !reg_mode_reg && (bits_left_reg != '0)) begin
            case (lane_mode_reg)
                2'b01:   spi_sdo = {2'b00, top_nibble[3:2]};
                2'b10:   spi_sdo = top_nibble;
                default: spi_sdo = {3'b000, top_nibble[3]};
            endcase
        end
    end

    // Command shifter: LSB-in on sck rise, bit count saturating at 25
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cmd_shift_reg <= '0;
            cmd_cnt_reg   <= '0;
        end else if (csn_fall) begin
            cmd_shift_reg <= '0;
            cmd_cnt_reg   <= '0;
        end else if (sck_rise && !csn_s) begin
            cmd_shift_reg <= {cmd_shift_reg[22:0], sdi_s};
            if (cmd_cnt_reg != 5'd25)
                cmd_cnt_reg <= cmd_cnt_reg + 5'd1;
        end
    end

    // Register frame commit and decode on csn rise with exactly 24 bits
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            reg_cmd_reg       <= '0;
            reg_cmd_valid_reg <= 1'b0;
            reg_mode_reg      <= 1'b0;
            lane_mode_reg     <= 2'b00;
        end else begin
            reg_cmd_valid_reg <= 1'b0;
            if (csn_rise && (cmd_cnt_reg == 5'd24)) begin
                reg_cmd_reg       <= cmd_shift_reg;
                reg_cmd_valid_reg <= 1'b1;
                if (cmd_shift_reg[23:21] == 3'b101)
                    reg_mode_reg <= 1'b1;
                else if (reg_mode_reg && (cmd_shift_reg[23:8] == {1'b1, 15'h0020}))
                    lane_mode_reg <= cmd_shift_reg[7:6];
                else if (reg_mode_reg && (cmd_shift_reg[23:8] == {1'b1, 15'h0014}) && cmd_shift_reg[0])
                    reg_mode_reg <= 1'b0;
            end
        end
    end

    assign reg_cmd       = reg_cmd_reg;
    assign reg_cmd_valid = reg_cmd_valid_reg;
    assign status        = {3'b000, conv_overrun_reg, data_ready_reg, reg_mode_reg, lane_mode_reg};

endmodule
